// File: rtl/serial_rx_framer_if.sv
// serial_rx_framer_if: serial line in, framed byte and status pulses out
interface serial_rx_framer_if;
  logic       serialIn;
  logic [7:0] parallelOut;
  logic       dataValid;
  logic       frameErr;
  logic       busy;
  modport master (output serialIn, input parallelOut, dataValid, frameErr, busy);
  modport slave  (input serialIn, output parallelOut, dataValid, frameErr, busy);
endinterface

// File: rtl/serial_rx_framer.sv
// serial_rx_framer: 8N1 serial receiver; samples mid-bit and emits one byte per good frame
module serial_rx_framer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  serial_rx_framer_if.slave bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          sync1_q, sync2_q;
  logic          cnt_full, cnt_half;
  assign cnt_full = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign cnt_half = cnt_q == CW'(HALF - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      sync1_q   <= bus.serialIn;
      sync2_q   <= sync1_q;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!sync2_q) state_d = START;
      end
      START: if (cnt_half) begin
        // a start bit that is gone by mid-bit is a glitch
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = sync2_q ? IDLE : DATA;
      end
      DATA: if (cnt_full) begin
        cnt_d     = '0;
        shift_d   = {sync2_q, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_full) begin
        cnt_d   = '0;
        state_d = IDLE;
        valid_d = sync2_q;
        err_d   = !sync2_q;
        data_d  = sync2_q ? shift_q : data_q;
      end
    endcase
  end
  assign bus.parallelOut = data_q;
  assign bus.dataValid   = valid_q;
  assign bus.frameErr    = err_q;
  assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_serial_rx_framer.sv
// tb_serial_rx_framer: directed frames against a 4 clk/bit and a 16 clk/bit receiver
module tb_serial_rx_framer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   e0;
  int   dv_n = 0, fe_n = 0, busy_n = 0, both_n = 0;
  int   dv_cyc = 0, dv_prev = 0, fe_cyc = 0;
  logic [7:0] dv_data = '0, dv_prev_data = '0;
  int   dvb_n = 0, dvb_cyc = 0;
  int   s_dv, s_fe, s_busy;
  serial_rx_framer_if a_if ();
  serial_rx_framer_if b_if ();
  serial_rx_framer #(.CLKS_PER_BIT(4))  dut_a (.clk(clk), .rst(rst), .bus(a_if));
  serial_rx_framer #(.CLKS_PER_BIT(16)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (a_if.dataValid) begin
      dv_n++;
      dv_prev = dv_cyc;
      dv_cyc = cyc;
      dv_prev_data = dv_data;
      dv_data = a_if.parallelOut;
    end
    if (a_if.frameErr) begin
      fe_n++;
      fe_cyc = cyc;
    end
    if (a_if.busy) busy_n++;
    if (a_if.dataValid && a_if.frameErr) both_n++;
    if (b_if.dataValid) begin
      dvb_n++;
      dvb_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic send(input bit sel_b, input logic [9:0] f, input int nbits);
    e0 = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      if (sel_b) b_if.serialIn = f[i];
      else a_if.serialIn = f[i];
      repeat (sel_b ? 16 : 4) @(negedge clk);
    end
    #1;
  endtask
  initial begin
    a_if.serialIn = 1'b1;
    b_if.serialIn = 1'b1;
    settle(2);
    chk("rst_pout", a_if.parallelOut, 8'h00);
    chk("rst_dv", a_if.dataValid, 1'b0);
    chk("rst_fe", a_if.frameErr, 1'b0);
    chk("rst_busy", a_if.busy, 1'b0);
    rst = 1'b1;
    settle(4);
    s_fe = fe_n;
    send(1'b0, 10'b1110010100, 10);
    a_if.serialIn = 1'b1;
    settle(6);
    chk("f1_dv_count", dv_n, 1);
    chk("f1_latency", dv_cyc - e0, 40);
    chk("f1_pout", a_if.parallelOut, 8'hCA);
    chk("f1_no_fe", fe_n - s_fe, 0);
    s_dv = dv_n;
    send(1'b0, 10'b1110010100, 10);
    send(1'b0, 10'b1001011100, 10);
    a_if.serialIn = 1'b1;
    settle(6);
    chk("b2b_dv_count", dv_n - s_dv, 2);
    chk("b2b_spacing", dv_cyc - dv_prev, 40);
    chk("b2b_first", dv_prev_data, 8'hCA);
    chk("b2b_second", a_if.parallelOut, 8'h2E);
    s_dv = dv_n;
    s_fe = fe_n;
    s_busy = busy_n;
    a_if.serialIn = 1'b0;
    @(negedge clk);
    a_if.serialIn = 1'b1;
    settle(10);
    chk("glitch_busy", busy_n - s_busy, 2);
    chk("glitch_dv", dv_n - s_dv, 0);
    chk("glitch_fe", fe_n - s_fe, 0);
    chk("glitch_pout", a_if.parallelOut, 8'h2E);
    s_dv = dv_n;
    s_fe = fe_n;
    send(1'b0, {1'b0, 8'h55, 1'b0}, 10);
    a_if.serialIn = 1'b1;
    settle(12);
    chk("ferr_count", fe_n - s_fe, 1);
    chk("ferr_latency", fe_cyc - e0, 40);
    chk("ferr_dv", dv_n - s_dv, 0);
    chk("ferr_pout", a_if.parallelOut, 8'h2E);
    s_dv = dv_n;
    s_fe = fe_n;
    send(1'b0, {1'b1, 8'hA5, 1'b0}, 5);
    a_if.serialIn = 1'b0;
    settle(2);
    chk("mid_busy", a_if.busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_pout", a_if.parallelOut, 8'h00);
    chk("arst_busy", a_if.busy, 1'b0);
    chk("arst_dv", a_if.dataValid, 1'b0);
    chk("arst_fe", a_if.frameErr, 1'b0);
    // hold reset across d4..d6, release with the line high for d7 and stop
    repeat (2) @(negedge clk);
    a_if.serialIn = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    settle(50);
    chk("arst_no_dv", dv_n - s_dv, 0);
    chk("arst_no_fe", fe_n - s_fe, 0);
    chk("arst_idle", a_if.busy, 1'b0);
    send(1'b0, {1'b1, 8'hA5, 1'b0}, 10);
    a_if.serialIn = 1'b1;
    settle(6);
    chk("post_rst_dv", dv_n - s_dv, 1);
    chk("post_rst_pout", a_if.parallelOut, 8'hA5);
    chk("post_rst_latency", dv_cyc - e0, 40);
    send(1'b1, {1'b1, 8'h3C, 1'b0}, 10);
    b_if.serialIn = 1'b1;
    settle(8);
    chk("cpb16_dv", dvb_n, 1);
    chk("cpb16_pout", b_if.parallelOut, 8'h3C);
    chk("cpb16_latency", dvb_cyc - e0, 154);
    chk("never_both", both_n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
